// File: rtl/duck_flight_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// duck_flight_ctrl : per-duck flight / hit-hold / fall sequencer driving an
// external down_counter (ld/en/data out, done in).            Revision 1.0
// ---------------------------------------------------------------------------
module duck_flight_ctrl #(
   parameter int N          = 10,
   parameter int COORD_W    = 10,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479,
   parameter int HOLD_TICKS = 60,
   parameter int FALL_TICKS = 2,
   parameter int FALL_STEP  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] init_x,
   input  logic [COORD_W-1:0] init_y,
   input  logic               init_dx,
   input  logic               init_dy,
   input  logic [N-1:0]       speed,
   input  logic               escape_en,
   input  logic               hit,
   input  logic               tick,
   output logic               cnt_ld,
   output logic               cnt_en,
   output logic [N-1:0]       cnt_data,
   input  logic               cnt_done,
   output logic [COORD_W-1:0] duck_x,
   output logic [COORD_W-1:0] duck_y,
   output logic               flying,
   output logic               falling,
   output logic               shot_down,
   output logic               escaped
);

   localparam logic [COORD_W-1:0] c_x_max     = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] c_y_max     = COORD_W'(Y_MAX);
   localparam logic [COORD_W-1:0] c_one       = COORD_W'(1);
   localparam logic [COORD_W:0]   c_fall_inc  = (COORD_W+1)'(FALL_STEP);
   localparam logic [N-1:0]       c_hold_data = N'(HOLD_TICKS);
   localparam logic [N-1:0]       c_fall_data = N'(FALL_TICKS);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_F_LOAD  = 4'd1,
      S_F_WAIT  = 4'd2,
      S_F_STEP  = 4'd3,
      S_H_LOAD  = 4'd4,
      S_H_WAIT  = 4'd5,
      S_D_LOAD  = 4'd6,
      S_D_WAIT  = 4'd7,
      S_D_STEP  = 4'd8,
      S_DOWN    = 4'd9,
      S_ESCAPED = 4'd10
   } state_t;

   state_t             r_state, w_state_n;
   logic [COORD_W-1:0] r_x, w_x_n;
   logic [COORD_W-1:0] r_y, w_y_n;
   logic               r_dx, w_dx_n;
   logic               r_dy, w_dy_n;
   logic [N-1:0]       r_speed, w_speed_n;
   logic [N-1:0]       r_data, w_data_n;
   logic [COORD_W:0]   w_fall_sum;
   logic               w_in_flight;

   // One extra bit so a fall near the bottom of the range cannot wrap.
   assign w_fall_sum  = {1'b0, r_y} + c_fall_inc;
   assign w_in_flight = (r_state == S_F_LOAD) || (r_state == S_F_WAIT) || (r_state == S_F_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_dx    <= 1'b0;
         r_dy    <= 1'b0;
         r_speed <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_n;
         r_x     <= w_x_n;
         r_y     <= w_y_n;
         r_dx    <= w_dx_n;
         r_dy    <= w_dy_n;
         r_speed <= w_speed_n;
         r_data  <= w_data_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_x_n     = r_x;
      w_y_n     = r_y;
      w_dx_n    = r_dx;
      w_dy_n    = r_dy;
      w_speed_n = r_speed;
      w_data_n  = r_data;

      // cnt_data is loaded on entry to a *_LOAD state so it is valid during it.
      if (hit && w_in_flight) begin
         w_state_n = S_H_LOAD;
         w_data_n  = c_hold_data;
      end else begin
         case (r_state)
            S_IDLE, S_DOWN, S_ESCAPED: begin
               if (start) begin
                  w_state_n = S_F_LOAD;
                  w_speed_n = speed;
                  w_data_n  = speed;
                  w_dx_n    = init_dx;
                  w_dy_n    = init_dy;
                  w_x_n     = (init_x > c_x_max) ? c_x_max : init_x;
                  w_y_n     = (init_y > c_y_max) ? c_y_max : init_y;
               end
            end
            S_F_LOAD: w_state_n = S_F_WAIT;
            S_F_WAIT: if (cnt_done) w_state_n = S_F_STEP;
            S_F_STEP: begin
               if (r_dy && (r_y == '0) && escape_en) begin
                  w_state_n = S_ESCAPED;
               end else begin
                  w_state_n = S_F_LOAD;
                  w_data_n  = r_speed;
                  if (r_dx) begin
                     if (r_x >= c_x_max) begin
                        w_dx_n = 1'b0;
                        w_x_n  = c_x_max - c_one;
                     end else begin
                        w_x_n  = r_x + c_one;
                     end
                  end else if (r_x == '0) begin
                     w_dx_n = 1'b1;
                     w_x_n  = c_one;
                  end else begin
                     w_x_n  = r_x - c_one;
                  end
                  if (!r_dy) begin
                     if (r_y >= c_y_max) begin
                        w_dy_n = 1'b1;
                        w_y_n  = c_y_max - c_one;
                     end else begin
                        w_y_n  = r_y + c_one;
                     end
                  end else if (r_y == '0) begin
                     w_dy_n = 1'b0;
                     w_y_n  = c_one;
                  end else begin
                     w_y_n  = r_y - c_one;
                  end
               end
            end
            S_H_LOAD: w_state_n = S_H_WAIT;
            S_H_WAIT: begin
               if (cnt_done) begin
                  w_state_n = S_D_LOAD;
                  w_data_n  = c_fall_data;
               end
            end
            S_D_LOAD: w_state_n = S_D_WAIT;
            S_D_WAIT: if (cnt_done) w_state_n = S_D_STEP;
            S_D_STEP: begin
               if (w_fall_sum >= {1'b0, c_y_max}) begin
                  w_y_n     = c_y_max;
                  w_state_n = S_DOWN;
               end else begin
                  w_y_n     = w_fall_sum[COORD_W-1:0];
                  w_state_n = S_D_LOAD;
                  w_data_n  = c_fall_data;
               end
            end
            default: w_state_n = S_IDLE;
         endcase
      end
   end

   assign cnt_ld    = (r_state == S_F_LOAD) || (r_state == S_H_LOAD) || (r_state == S_D_LOAD);
   assign cnt_en    = tick && ((r_state == S_F_WAIT) || (r_state == S_H_WAIT) || (r_state == S_D_WAIT));
   assign cnt_data  = r_data;
   assign duck_x    = r_x;
   assign duck_y    = r_y;
   assign flying    = w_in_flight;
   assign falling   = (r_state == S_H_LOAD) || (r_state == S_H_WAIT) || (r_state == S_D_LOAD)
                   || (r_state == S_D_WAIT) || (r_state == S_D_STEP);
   assign shot_down = (r_state == S_DOWN);
   assign escaped   = (r_state == S_ESCAPED);

endmodule
`default_nettype wire

// File: tb/tb_duck_flight_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_duck_flight_ctrl : directed + random bench with a behavioural duck model
// and a behavioural down_counter.                             Revision 1.0
// ---------------------------------------------------------------------------
module tb_duck_flight_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, init_dx, init_dy, escape_en, hit, tick;
   logic [9:0] init_x, init_y, speed;
   logic       cnt_ld, cnt_en, cnt_done;
   logic [9:0] cnt_data, duck_x, duck_y;
   logic       flying, falling, shot_down, escaped;
   logic [9:0] tb_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   duck_flight_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .init_x(init_x), .init_y(init_y),
      .init_dx(init_dx), .init_dy(init_dy), .speed(speed), .escape_en(escape_en),
      .hit(hit), .tick(tick), .cnt_ld(cnt_ld), .cnt_en(cnt_en), .cnt_data(cnt_data),
      .cnt_done(cnt_done), .duck_x(duck_x), .duck_y(duck_y), .flying(flying),
      .falling(falling), .shot_down(shot_down), .escaped(escaped)
   );

   always #5 clk = ~clk;

   // Paired down_counter: done goes sticky one en-cycle after reaching zero.
   always @(posedge clk) begin
      if (reset) begin
         tb_cnt   <= '0;
         cnt_done <= 1'b0;
      end else if (cnt_ld) begin
         tb_cnt   <= cnt_data;
         cnt_done <= 1'b0;
      end else if (cnt_en) begin
         if (tb_cnt == 0) cnt_done <= 1'b1;
         else             tb_cnt   <= tb_cnt - 10'd1;
      end
   end

   // Reference model: what the duck is doing, and which phase of a step it is in.
   typedef enum {M_IDLE, M_FLY, M_HOLD, M_FALL, M_DOWN, M_ESC} mode_t;
   typedef enum {P_LOAD, P_WAIT, P_STEP} phase_t;
   mode_t  m_mode  = M_IDLE;
   phase_t m_phase = P_LOAD;
   int     m_x = 0, m_y = 0, m_speed = 0, m_data = 0, m_cnt = 0;
   bit     m_dx = 0, m_dy = 0, m_done = 0;

   function automatic bit m_ld();
      return (m_phase == P_LOAD) && (m_mode inside {M_FLY, M_HOLD, M_FALL});
   endfunction

   function automatic bit m_en();
      return (m_phase == P_WAIT) && (m_mode inside {M_FLY, M_HOLD, M_FALL}) && tick;
   endfunction

   task automatic fly_step();
      if (m_dy && m_y == 0 && escape_en) begin
         m_mode = M_ESC;
         return;
      end
      if (m_dx) begin
         if (m_x >= 639) begin m_dx = 0; m_x = 638; end
         else m_x = m_x + 1;
      end else if (m_x == 0) begin m_dx = 1; m_x = 1; end
      else m_x = m_x - 1;
      if (!m_dy) begin
         if (m_y >= 479) begin m_dy = 1; m_y = 478; end
         else m_y = m_y + 1;
      end else if (m_y == 0) begin m_dy = 0; m_y = 1; end
      else m_y = m_y - 1;
      m_phase = P_LOAD;
      m_data  = m_speed;
   endtask

   task automatic model_update();
      bit ld, en, n_done;
      int n_cnt;
      ld = m_ld();
      en = m_en();
      n_cnt  = m_cnt;
      n_done = m_done;
      if (ld) begin n_cnt = m_data; n_done = 0; end
      else if (en) begin
         if (m_cnt == 0) n_done = 1;
         else n_cnt = m_cnt - 1;
      end
      if (reset) begin
         m_mode = M_IDLE; m_phase = P_LOAD; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
         m_speed = 0; m_data = 0; m_cnt = 0; m_done = 0;
         return;
      end
      if (m_mode == M_FLY && hit) begin
         m_mode = M_HOLD; m_phase = P_LOAD; m_data = 60;
      end else begin
         case (m_mode)
            M_IDLE, M_DOWN, M_ESC: if (start) begin
               m_mode = M_FLY; m_phase = P_LOAD;
               m_x = (int'(init_x) > 639) ? 639 : int'(init_x);
               m_y = (int'(init_y) > 479) ? 479 : int'(init_y);
               m_dx = init_dx; m_dy = init_dy;
               m_speed = int'(speed); m_data = int'(speed);
            end
            M_FLY: case (m_phase)
               P_LOAD: m_phase = P_WAIT;
               P_WAIT: if (m_done) m_phase = P_STEP;
               P_STEP: fly_step();
            endcase
            M_HOLD: if (m_phase == P_LOAD) m_phase = P_WAIT;
                    else if (m_done) begin m_mode = M_FALL; m_phase = P_LOAD; m_data = 2; end
            M_FALL: case (m_phase)
               P_LOAD: m_phase = P_WAIT;
               P_WAIT: if (m_done) m_phase = P_STEP;
               P_STEP: if (m_y + 4 >= 479) begin m_y = 479; m_mode = M_DOWN; end
                       else begin m_y = m_y + 4; m_phase = P_LOAD; m_data = 2; end
            endcase
            default: ;
         endcase
      end
      m_cnt  = n_cnt;
      m_done = n_done;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_eq("ctrl", {cnt_ld, cnt_en, cnt_data}, {m_ld(), m_en(), 10'(m_data)});
      check_eq("pos", {duck_x, duck_y}, {10'(m_x), 10'(m_y)});
      check_eq("flags", {flying, falling, shot_down, escaped},
               {m_mode == M_FLY, m_mode inside {M_HOLD, M_FALL}, m_mode == M_DOWN, m_mode == M_ESC});
   endtask

   // Called at a negedge with inputs set; returns at the next negedge with pulses cleared.
   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
      @(negedge clk);
      start = 1'b0;
      hit   = 1'b0;
      reset = 1'b0;
   endtask

   task automatic launch(input int ix, input int iy, input bit idx, input bit idy, input int spd);
      reset = 1'b1;
      cyc();
      start = 1'b1; init_x = 10'(ix); init_y = 10'(iy);
      init_dx = idx; init_dy = idy; speed = 10'(spd);
      cyc();
   endtask

   initial begin
      logic [15:0] ld_mask;
      logic [19:0] p8, p15, pos0;
      logic [29:0] ys;
      logic [9:0]  last_y;
      bit          found;

      reset = 1'b1; start = 1'b0; hit = 1'b0; tick = 1'b1; escape_en = 1'b0;
      init_x = '0; init_y = '0; init_dx = 1'b0; init_dy = 1'b0; speed = '0;
      @(negedge clk);
      cyc();
      check_eq("reset_outs", {cnt_ld, cnt_en, cnt_data, duck_x, duck_y,
                              flying, falling, shot_down, escaped}, 64'd0);

      // Step timing and first two flight positions.
      launch(100, 200, 1, 1, 3);
      ld_mask = '0;
      ld_mask[1] = cnt_ld;
      p8 = '0; p15 = '0;
      for (int k = 2; k <= 15; k++) begin
         cyc();
         ld_mask[k] = cnt_ld;
         if (k == 8)  p8  = {duck_x, duck_y};
         if (k == 15) p15 = {duck_x, duck_y};
      end
      check_eq("ld_cycles", ld_mask, 16'h8102);
      check_eq("step1", p8, {10'd101, 10'd199});
      check_eq("step2", p15, {10'd102, 10'd198});

      // Horizontal bounces at both edges.
      launch(639, 200, 1, 1, 0);
      repeat (4) cyc();
      check_eq("right_edge", duck_x, 10'd638);
      repeat (4) cyc();
      check_eq("right_edge2", duck_x, 10'd637);
      launch(0, 200, 0, 1, 0);
      repeat (4) cyc();
      check_eq("left_edge", duck_x, 10'd1);

      // Escape versus top bounce.
      escape_en = 1'b1;
      launch(100, 0, 1, 1, 0);
      repeat (4) cyc();
      check_eq("escape", {escaped, flying, duck_x, duck_y}, {1'b1, 1'b0, 10'd100, 10'd0});
      escape_en = 1'b0;
      launch(100, 0, 1, 1, 0);
      repeat (4) cyc();
      check_eq("top_bounce", {duck_x, duck_y}, {10'd101, 10'd1});
      repeat (4) cyc();
      check_eq("top_bounce2", duck_y, 10'd2);

      // Hit lands in the same cycle the counter reports done.
      launch(300, 300, 1, 0, 2);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_mode == M_FLY && m_phase == P_WAIT && m_done) found = 1;
         else cyc();
      end
      check_eq("hit_wait", found, 1);
      pos0 = {duck_x, duck_y};
      hit = 1'b1;
      cyc();
      check_eq("hit_hold", {cnt_ld, cnt_data, flying, falling}, {1'b1, 10'd60, 1'b0, 1'b1});
      check_eq("hit_pos", {duck_x, duck_y}, pos0);

      // Fall with saturation at the ground line, then relaunch.
      launch(200, 470, 1, 0, 0);
      hit = 1'b1;
      cyc();
      ys = '0;
      last_y = duck_y;
      for (int i = 0; i < 400 && !shot_down; i++) begin
         cyc();
         if (duck_y != last_y) begin
            ys = {ys[19:0], duck_y};
            last_y = duck_y;
         end
      end
      check_eq("fall_seq", ys, {10'd474, 10'd478, 10'd479});
      check_eq("fall_down", {shot_down, duck_x}, {1'b1, 10'd200});
      start = 1'b1; init_x = 10'd20; init_y = 10'd30; speed = 10'd1;
      hit = 1'b1;
      cyc();
      check_eq("relaunch", {shot_down, flying, duck_x, duck_y}, {1'b0, 1'b1, 10'd20, 10'd30});

      // Reset in the middle of a fall.
      launch(200, 100, 1, 0, 1);
      hit = 1'b1;
      cyc();
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_mode == M_FALL && m_phase == P_WAIT) found = 1;
         else cyc();
      end
      check_eq("fall_wait", found, 1);
      reset = 1'b1;
      cyc();
      check_eq("mid_reset", {cnt_ld, cnt_en, cnt_data, duck_x, duck_y,
                             flying, falling, shot_down, escaped}, 64'd0);

      // Time base stalled while waiting.
      launch(50, 50, 1, 1, 3);
      cyc();
      tick = 1'b0;
      pos0 = {duck_x, duck_y};
      repeat (20) cyc();
      check_eq("tick_stall", {duck_x, duck_y, flying, cnt_en}, {pos0, 1'b1, 1'b0});
      tick = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         tick   = ($urandom_range(0, 3) != 0);
         hit    = ($urandom_range(0, 59) == 0);
         reset  = ($urandom_range(0, 799) == 0);
         start  = ($urandom_range(0, 29) == 0);
         speed  = 10'($urandom_range(0, 4));
         init_dx = 1'($urandom_range(0, 1));
         init_dy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) escape_en = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       init_x = 10'($urandom_range(0, 2));
            1:       init_x = 10'($urandom_range(636, 700));
            default: init_x = 10'($urandom_range(0, 1023));
         endcase
         case ($urandom_range(0, 3))
            0:       init_y = 10'($urandom_range(0, 2));
            1:       init_y = 10'($urandom_range(470, 520));
            default: init_y = 10'($urandom_range(0, 1023));
         endcase
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
